// File: rtl/axi4_lite_cmd_master_if.sv
// Command/response port plus AXI4-Lite master channels for axi4_lite_cmd_master.
// The master modport is the command master's view; slave is the sequencer/AXI-slave side.
interface axi4_lite_cmd_master_if #(
    parameter int ALEN = 32,
    parameter int DLEN = 32,
    parameter int SLEN = DLEN / 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ALEN-1:0]   cmd_addr;
    logic [DLEN-1:0]   cmd_wdata;
    logic [SLEN-1:0]   cmd_wstrb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DLEN-1:0]   rsp_rdata;
    logic [1:0]        rsp_resp;

    logic              awvalid;
    logic              awready;
    logic [ALEN-1:0]   awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [DLEN-1:0]   wdata;
    logic [SLEN-1:0]   wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ALEN-1:0]   araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DLEN-1:0]   rdata;
    logic [1:0]        rresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
               awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
               awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready
    );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one response back.
// All AXI outputs come straight from registers; misaligned commands are answered locally with SLVERR.
module axi4_lite_cmd_master #(
    parameter int ALEN = 32,
    parameter int DLEN = 32,
    parameter int SLEN = DLEN / 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    axi4_lite_cmd_master_if.master    bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] WB   = 3'd2;
    localparam logic [2:0] RA   = 3'd3;
    localparam logic [2:0] RD   = 3'd4;
    localparam logic [2:0] RSP  = 3'd5;

    localparam int ALIGN = (SLEN > 1) ? $clog2(SLEN) : 1;

    logic [2:0]      r_state;
    logic            r_write;
    logic [ALEN-1:0] r_addr;
    logic [DLEN-1:0] r_wdata;
    logic [SLEN-1:0] r_wstrb;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_aw_done;
    logic            r_w_done;
    logic            r_bready;
    logic            r_arvalid;
    logic            r_rready;
    logic [DLEN-1:0] r_rsp_rdata;
    logic [1:0]      r_rsp_resp;

    logic            w_misaligned;
    logic            w_aw_fin;
    logic            w_w_fin;

    assign w_misaligned = (SLEN > 1) ? (|bus.cmd_addr[ALIGN-1:0]) : 1'b0;
    // A channel counts as finished if it completed earlier or is handshaking this cycle.
    assign w_aw_fin     = r_aw_done | (r_awvalid & bus.awready);
    assign w_w_fin      = r_w_done  | (r_wvalid  & bus.wready);

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RSP);
    assign bus.rsp_write = r_write;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_resp  = r_rsp_resp;

    assign bus.awvalid = r_awvalid;
    assign bus.awaddr  = r_addr;
    assign bus.awprot  = 3'b000;
    assign bus.wvalid  = r_wvalid;
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = r_wstrb;
    assign bus.bready  = r_bready;
    assign bus.arvalid = r_arvalid;
    assign bus.araddr  = r_addr;
    assign bus.arprot  = 3'b000;
    assign bus.rready  = r_rready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_write <= bus.cmd_write;
                        r_addr  <= bus.cmd_addr;
                        r_wdata <= bus.cmd_wdata;
                        r_wstrb <= bus.cmd_wstrb;
                        if (w_misaligned) begin
                            r_rsp_resp  <= 2'b10;
                            r_rsp_rdata <= '0;
                            r_state     <= RSP;
                        end else if (bus.cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RA;
                        end
                    end
                end
                WR: begin
                    if (r_awvalid && bus.awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && bus.wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= WB;
                    end
                end
                WB: begin
                    if (bus.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= bus.bresp;
                        r_rsp_rdata <= '0;
                        r_state     <= RSP;
                    end
                end
                RA: begin
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD;
                    end
                end
                RD: begin
                    if (bus.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= bus.rdata;
                        r_rsp_resp  <= bus.rresp;
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
